// File: rtl/fsmc_pkg.sv
// Shared FSM encoding and constants for the FSMC register bank.
package fsmc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_ACT = 2'd1,
        RD_ACT = 2'd2
    } fsm_state_e;

    localparam logic [7:0] LED_MATCH = 8'h16;

endpackage

// File: rtl/fsmc_sync2.sv
// Two-flop synchronizer with a configurable reset value.
module fsmc_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    always_comb ff_d = {ff_q[0], d};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ff_q <= {2{RST_VAL}};
        else        ff_q <= ff_d;
    end

    assign q = ff_q[1];

endmodule

// File: rtl/fsmc_regbank.sv
// FSMC slave register bank: RW registers, RO inputs, write strobes
// and a write counter behind a synchronized async bus.
module fsmc_regbank
    import fsmc_pkg::*;
#(
    parameter int            AW      = 4,
    parameter int            DW      = 8,
    parameter int            DEPTH   = 16,
    parameter int            NRO     = 4,
    parameter int            NE_SEL  = 0,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [AW-1:0]       FSMC_A,
    input  logic                FSMC_NOE,
    input  logic                FSMC_NWE,
    input  logic [1:0]          FSMC_NE,
    inout  wire  [DW-1:0]       FSMC_D,
    output logic [DEPTH*DW-1:0] REG_OUT,
    input  logic [NRO*DW-1:0]   RO_IN,
    output logic [DEPTH-1:0]    WR_STB,
    output logic [7:0]          WR_CNT,
    output logic                LED2
);

    localparam int NRW = DEPTH - NRO;

    logic noe_s, nwe_s, ne_s, cs_s;
    logic unused_ne;

    assign unused_ne = ^FSMC_NE;

    fsmc_sync2 #(.RST_VAL(1'b1)) u_sync_noe (
        .CLK(CLK), .RST_N(RST_N), .d(FSMC_NOE), .q(noe_s)
    );
    fsmc_sync2 #(.RST_VAL(1'b1)) u_sync_nwe (
        .CLK(CLK), .RST_N(RST_N), .d(FSMC_NWE), .q(nwe_s)
    );
    fsmc_sync2 #(.RST_VAL(1'b1)) u_sync_ne (
        .CLK(CLK), .RST_N(RST_N), .d(FSMC_NE[NE_SEL]), .q(ne_s)
    );

    assign cs_s = !ne_s;

    fsm_state_e          state_q, state_d;
    logic [DW-1:0]       regs_q [NRW];
    logic [DW-1:0]       regs_d [NRW];
    logic [DEPTH-1:0]    stb_q, stb_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DW-1:0]       rd_q, rd_d;
    logic                led2_q, led2_d;
    logic [1:0]          vld_q, vld_d;
    logic                armed_q, armed_d;
    logic [DW-1:0]       rd_word;
    int                  a_i;

    // Strobes held low across reset must be seen high before a new
    // transaction; vld_q marks when the sync pipeline holds real samples.
    always_comb begin
        vld_d   = {vld_q[0], 1'b1};
        armed_d = armed_q | (vld_q[1] & nwe_s & noe_s);
    end

    always_comb begin
        a_i     = int'(FSMC_A);
        rd_word = '0;
        for (int i = 0; i < NRW; i++) begin
            if (a_i == i) rd_word = regs_q[i];
        end
        for (int j = 0; j < NRO; j++) begin
            if (a_i == NRW + j) rd_word = RO_IN[j*DW +: DW];
        end
    end

    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        stb_d   = '0;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE: begin
                if (armed_q && cs_s && !nwe_s) begin
                    state_d = WR_ACT;
                    for (int i = 0; i < NRW; i++) begin
                        if (a_i == i) begin
                            regs_d[i] = FSMC_D;
                            stb_d[i]  = 1'b1;
                            cnt_d     = cnt_q + 8'd1;
                        end
                    end
                end else if (armed_q && cs_s && !noe_s) begin
                    rd_d    = rd_word;
                    state_d = RD_ACT;
                end
            end
            WR_ACT: begin
                if (nwe_s || !cs_s) state_d = IDLE;
            end
            RD_ACT: begin
                if (noe_s || !cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        led2_d = 1'b0;
        for (int i = 0; i < NRW; i++) begin
            if (i == 4) led2_d = (regs_q[i] == DW'(LED_MATCH));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            for (int i = 0; i < NRW; i++) regs_q[i] <= RST_VAL;
            stb_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            led2_q  <= (RST_VAL == DW'(LED_MATCH));
            vld_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            stb_q   <= stb_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            led2_q  <= led2_d;
            vld_q   <= vld_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        REG_OUT = '0;
        for (int i = 0; i < NRW; i++) REG_OUT[i*DW +: DW] = regs_q[i];
    end

    assign FSMC_D = (state_q == RD_ACT) ? rd_q : {DW{1'bz}};
    assign WR_STB = stb_q;
    assign WR_CNT = cnt_q;
    assign LED2   = led2_q;

endmodule

// File: tb/tb_fsmc_regbank.sv
// Scoreboard bench for fsmc_regbank: bus writes/reads, RO, wrap, reset.
module tb_fsmc_regbank;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   fsmc_a;
    logic         noe, nwe;
    logic [1:0]   ne;
    wire  [7:0]   fsmc_d;
    logic [7:0]   tb_d;
    logic         tb_den;
    logic [127:0] reg_out;
    logic [31:0]  ro_in;
    logic [15:0]  wr_stb;
    logic [7:0]   wr_cnt;
    logic         led2;

    int           n_vec = 0;
    int           n_err = 0;
    int           stb_cnt [16];
    logic [7:0]   exp_q [$];

    always #10 clk = ~clk;

    assign fsmc_d = tb_den ? tb_d : 8'hzz;

    // Undriven bus reads back as all ones.
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (fsmc_d[g]);
    end

    fsmc_regbank dut (
        .CLK(clk), .RST_N(rst_n), .FSMC_A(fsmc_a),
        .FSMC_NOE(noe), .FSMC_NWE(nwe), .FSMC_NE(ne),
        .FSMC_D(fsmc_d), .REG_OUT(reg_out), .RO_IN(ro_in),
        .WR_STB(wr_stb), .WR_CNT(wr_cnt), .LED2(led2)
    );

    initial for (int i = 0; i < 16; i++) stb_cnt[i] = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            if (wr_stb[i]) stb_cnt[i] = stb_cnt[i] + 1;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(logic [3:0] a, logic [7:0] d);
        fsmc_a = a; tb_d = d; tb_den = 1'b1; nwe = 1'b0;
        cyc(6);
        nwe = 1'b1;
        cyc(1);
        tb_den = 1'b0;
        cyc(4);
    endtask

    task automatic bus_read(logic [3:0] a, logic [7:0] e, string tag);
        exp_q.push_back(e);
        fsmc_a = a; noe = 1'b0;
        cyc(2);
        chk({tag, "_pre"}, fsmc_d, 8'hFF);
        cyc(1);
        if (exp_q.size() == 0) chk({tag, "_sb"}, 0, 1);
        else chk(tag, fsmc_d, exp_q[0]);
        cyc(3);
        noe = 1'b1;
        cyc(2);
        chk({tag, "_hold"}, fsmc_d, exp_q[0]);
        cyc(1);
        void'(exp_q.pop_front());
        chk({tag, "_rel"}, fsmc_d, 8'hFF);
        cyc(2);
    endtask

    logic [127:0] snap;
    int           s;

    initial begin
        rst_n = 1'b0; noe = 1'b1; nwe = 1'b1; ne = 2'b11;
        fsmc_a = '0; tb_d = '0; tb_den = 1'b0;
        ro_in = {8'h44, 8'h33, 8'h3C, 8'h11};
        cyc(3);
        chk("rst_cnt", wr_cnt, 0);
        chk("rst_regs", |reg_out, 0);
        chk("rst_led", led2, 0);
        chk("rst_stb", wr_stb, 0);
        chk("rst_bus", fsmc_d, 8'hFF);
        rst_n = 1'b1;
        cyc(4);
        ne = 2'b10;

        s = stb_cnt[4];
        bus_write(4'd4, 8'h16);
        chk("w4_reg", reg_out[39:32], 8'h16);
        chk("w4_stb", stb_cnt[4] - s, 1);
        chk("w4_cnt", wr_cnt, 1);
        chk("w4_led", led2, 1);

        bus_write(4'd2, 8'hA5);
        chk("w2_reg", reg_out[23:16], 8'hA5);
        bus_read(4'd2, 8'hA5, "rd2");
        bus_read(4'd4, 8'h16, "rd4");

        snap = reg_out;
        s = stb_cnt[13];
        bus_write(4'd13, 8'hFF);
        chk("w13_regs", reg_out == snap, 1);
        chk("w13_cnt", wr_cnt, 2);
        chk("w13_stb", stb_cnt[13] - s, 0);
        bus_read(4'd13, 8'h3C, "rd13");
        bus_read(4'd15, 8'h44, "rd15");

        ne = 2'b11;
        bus_write(4'd5, 8'h77);
        chk("nosel_reg", reg_out[47:40], 0);
        chk("nosel_cnt", wr_cnt, 2);
        ne = 2'b10;

        fsmc_a = 4'd6; tb_d = 8'h5A; tb_den = 1'b1;
        noe = 1'b0; nwe = 1'b0;
        cyc(6);
        tb_den = 1'b0;
        cyc(1);
        chk("both_bus", fsmc_d, 8'hFF);
        chk("both_reg", reg_out[55:48], 8'h5A);
        chk("both_cnt", wr_cnt, 3);
        noe = 1'b1; nwe = 1'b1;
        cyc(5);

        fsmc_a = 4'd2; noe = 1'b0;
        cyc(3);
        chk("rrst_drv", fsmc_d, 8'hA5);
        rst_n = 1'b0;
        #1;
        chk("rrst_bus", fsmc_d, 8'hFF);
        chk("rrst_regs", |reg_out, 0);
        chk("rrst_cnt", wr_cnt, 0);
        chk("rrst_led", led2, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("rrst_held", fsmc_d, 8'hFF);
        noe = 1'b1;
        cyc(4);
        bus_read(4'd2, 8'h00, "rd2_rst");

        s = stb_cnt[0];
        for (int i = 0; i < 256; i++) bus_write(4'd0, 8'(i));
        chk("wrap_cnt", wr_cnt, 0);
        chk("wrap_stb", stb_cnt[0] - s, 256);
        chk("wrap_reg", reg_out[7:0], 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fsmc_regbank.md
FSMC_REGBANK -- requirements
Module: fsmc_regbank

Interface
REQ-001 SHALL take parameter AW, default 4: FSMC address width.
REQ-002 SHALL take parameter DW, default 8: FSMC data width.
REQ-003 SHALL take parameter DEPTH, default 16 (≤ 2^AW): register count.
REQ-004 SHALL take parameter NRO, default 4: read-only registers at indices DEPTH-NRO..DEPTH-1.
REQ-005 SHALL take parameter NE_SEL, default 0: index of the FSMC_NE bit that selects this block.
REQ-006 SHALL take parameter RST_VAL, default 0: reset value of every RW register.
REQ-007 SHALL have port CLK  in  1  the single system clock (50 MHz); all logic is clocked by CLK.
REQ-008 SHALL have port RST_N  in  1  asynchronous active-low reset.
REQ-009 SHALL have port FSMC_A  in  AW  bus address.
REQ-010 SHALL have port FSMC_NOE  in  1  read strobe, active-low.
REQ-011 SHALL have port FSMC_NWE  in  1  write strobe, active-low.
REQ-012 SHALL have port FSMC_NE  in  2  chip enables, active-low.
REQ-013 SHALL have port FSMC_D  inout  DW  bidirectional data bus.
REQ-014 SHALL have port REG_OUT  out  DEPTH*DW  flattened RW register contents; register i occupies bits [i*DW +: DW].
REQ-015 SHALL have port RO_IN  in  NRO*DW  values returned for the read-only registers.
REQ-016 SHALL have port WR_STB  out  DEPTH  one-cycle pulse per register on each accepted write.
REQ-017 SHALL have port WR_CNT  out  8  count of accepted writes.
REQ-018 SHALL have port LED2  out  1  high while register 4 equals 8'h16.

Function
REQ-019 SHALL pass FSMC_NOE, FSMC_NWE and FSMC_NE[NE_SEL] each through a 2-flop synchronizer; cs_s = !NE_s.
REQ-020 SHALL implement an FSM with states IDLE, WR_ACT and RD_ACT.
REQ-021 In IDLE, cs_s && !nwe_s SHALL trigger a write: sample FSMC_A and FSMC_D that cycle, apply the write, then go to WR_ACT.
REQ-022 A write SHALL update register A only if A < DEPTH-NRO; the same write SHALL pulse WR_STB[A] for one cycle and increment WR_CNT, which wraps 8'hFF->8'h00.
REQ-023 A write to a read-only or out-of-range address (A ≥ DEPTH) SHALL change no register, produce no strobe and leave WR_CNT unchanged.
REQ-024 In IDLE, cs_s && !noe_s && nwe_s SHALL latch the read word into rd_q and go to RD_ACT.
REQ-025 The read word SHALL be: RW register for A < DEPTH-NRO; RO_IN slice (A-(DEPTH-NRO)) for DEPTH-NRO ≤ A < DEPTH; 0 for A ≥ DEPTH.
REQ-026 In RD_ACT, FSMC_D SHALL be driven with rd_q; FSMC_D SHALL be high-Z in every other state.
REQ-027 RD_ACT SHALL exit to IDLE when noe_s goes high or cs_s goes low; the bus SHALL release in the same cycle as the exit.
REQ-028 WR_ACT SHALL exit to IDLE when nwe_s goes high or cs_s goes low; exactly one write SHALL occur per NWE low pulse.
REQ-029 When NOE and NWE are both low in IDLE, the write SHALL take priority and the bus SHALL NOT be driven.
REQ-030 Latency SHALL be 3 CLK from the FSMC_NOE fall to the bus being driven, and 3 CLK from the FSMC_NWE fall to the register update; host DATAST SHALL be ≥ 5 CLK and data SHALL be held through NWE low.
REQ-031 LED2 SHALL be registered and SHALL be a pure function of register 4.

Reset
REQ-032 RST_N low SHALL asynchronously set: FSM=IDLE, FSMC_D high-Z, RW registers=RST_VAL, WR_STB=0, WR_CNT=0, rd_q=0, synchronizers to inactive (high), LED2=(RST_VAL==8'h16).
REQ-033 Reset asserted mid-transaction SHALL release the bus immediately and discard the transaction; after RST_N rises, a strobe still low SHALL be treated as a new transaction only after it is seen high first.

Structure
REQ-034 A shared package fsmc_pkg SHALL hold the FSM state encoding and the LED2 match constant 8'h16.
REQ-035 One sub-module, fsmc_sync2 (2-flop synchronizer with reset value), SHALL be instantiated per strobe.

Verification
REQ-036 Bench SHALL cover: write A=4 D=8'h16 -> REG_OUT[39:32]=8'h16, WR_STB[4] pulses once, WR_CNT=1, LED2=1.
REQ-037 Bench SHALL cover: write A=2 D=8'hA5, then read A=2 -> FSMC_D=8'hA5 from 3 CLK after NOE fall, high-Z 3 CLK after NOE rise.
REQ-038 Bench SHALL cover: write A=13 (read-only) D=8'hFF -> no register change, WR_CNT unchanged; read A=13 with RO_IN slice 1=8'h3C -> 8'h3C.
REQ-039 Bench SHALL cover: 256 writes to A=0 -> WR_CNT=0, exactly 256 WR_STB[0] pulses.
REQ-040 Bench SHALL cover: NE[NE_SEL] high with NWE pulsed -> no write; NOE and NWE low together -> write occurs, bus stays high-Z.
REQ-041 Bench SHALL cover: RST_N low during RD_ACT -> FSMC_D high-Z same cycle, all registers = RST_VAL.
